// File: rtl/fbr_feature_buffer.sv
// Ping-pong feature buffer: two windows of feature words between the Haar feature
// generator and the cascade classifier, with space/valid handshake flags.
module fbr_feature_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 128
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              iWrreq_FBR,
    input  logic [ADDR_W-1:0] iAddr_FBR,
    input  logic [DATA_W-1:0] iFeature,
    input  logic              iFull_FBR,
    input  logic              iRdreq,
    input  logic [ADDR_W-1:0] iAddr_Rd,
    input  logic              iRelease,
    output logic              oSpace,
    output logic              oValid,
    output logic [DATA_W-1:0] oData,
    output logic              oData_Valid,
    output logic              oOverflow
);

    logic [1:0]        cnt_q, cnt_d;
    logic              wbank_q, wbank_d;
    logic              rbank_q, rbank_d;
    logic              space_q, valid_q;
    logic              ovf_q, ovf_d;
    logic              dv_q;
    logic [DATA_W-1:0] data_q;

    logic              rel_ok, full_ok, wr_ok, rd_ok, is_full;

    // Both banks, indexed {bank, addr}; no reset so it maps onto block RAM.
    logic [DATA_W-1:0] mem_q [2*DEPTH];

    always_comb begin
        is_full = (cnt_q == 2'd2);
        rel_ok  = iRelease && (cnt_q != 2'd0);
        // A release in the same cycle frees a bank, so a completion at cnt=2 is legal.
        full_ok = iFull_FBR && (!is_full || rel_ok);
        wr_ok   = iWrreq_FBR && !is_full;
        rd_ok   = iRdreq && (cnt_q != 2'd0);
    end

    always_comb begin
        cnt_d   = cnt_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        unique case ({full_ok, rel_ok})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        if (full_ok) begin
            wbank_d = ~wbank_q;
        end
        if (rel_ok) begin
            rbank_d = ~rbank_q;
        end
        ovf_d = ovf_q
              | (iWrreq_FBR && is_full)
              | (iFull_FBR && is_full && !rel_ok);
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            cnt_q   <= 2'd0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            space_q <= 1'b1;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            space_q <= (cnt_d != 2'd2);
            valid_q <= (cnt_d != 2'd0);
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset_n && wr_ok) begin
            mem_q[{wbank_q, iAddr_FBR}] <= iFeature;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            dv_q   <= 1'b0;
            data_q <= '0;
        end else begin
            dv_q <= rd_ok;
            if (rd_ok) begin
                data_q <= mem_q[{rbank_q, iAddr_Rd}];
            end
        end
    end

    assign oSpace      = space_q;
    assign oValid      = valid_q;
    assign oOverflow   = ovf_q;
    assign oData       = data_q;
    assign oData_Valid = dv_q;

endmodule

// File: tb/tb_fbr_feature_buffer.sv
// Randomised and directed bench for fbr_feature_buffer against a window-queue model.
module tb_fbr_feature_buffer;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int D  = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic          full = 1'b0;
    logic          rd = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic          rel = 1'b0;
    logic          space, valid, dvalid, ovf;
    logic [DW-1:0] rdata;

    fbr_feature_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
        .iClk        (clk),
        .iReset_n    (rst_n),
        .iWrreq_FBR  (wr),
        .iAddr_FBR   (waddr),
        .iFeature    (wdata),
        .iFull_FBR   (full),
        .iRdreq      (rd),
        .iAddr_Rd    (raddr),
        .iRelease    (rel),
        .oSpace      (space),
        .oValid      (valid),
        .oData       (rdata),
        .oData_Valid (dvalid),
        .oOverflow   (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: banks plus a FIFO of completed windows (bank ids), oldest first.
    logic [31:0] m_mem [2][D];
    bit          m_known [2][D];
    int          m_ready [$];
    int          m_fill = 0;
    logic [31:0] m_data = '0;
    bit          m_dknown = 1'b1;
    bit          m_dv = 1'b0;
    bit          m_ovf = 1'b0;

    task automatic step();
        int n;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_ready.delete();
            m_fill   = 0;
            m_data   = '0;
            m_dknown = 1'b1;
            m_dv     = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            n    = m_ready.size();
            m_dv = rd && (n > 0);
            if (m_dv) begin
                m_data   = m_mem[m_ready[0]][raddr];
                m_dknown = m_known[m_ready[0]][raddr];
            end
            if (wr) begin
                if (n < 2) begin
                    m_mem[m_fill][waddr]   = wdata;
                    m_known[m_fill][waddr] = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (rel && n > 0) void'(m_ready.pop_front());
            if (full) begin
                if (m_ready.size() < 2) begin
                    m_ready.push_back(m_fill);
                    m_fill ^= 1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        check("space", 32'(space), 32'(m_ready.size() < 2));
        check("valid", 32'(valid), 32'(m_ready.size() > 0));
        check("dvalid", 32'(dvalid), 32'(m_dv));
        check("overflow", 32'(ovf), 32'(m_ovf));
        if (m_dknown) check("data", rdata, m_data);
    endtask

    task automatic drive(input bit w, input int wa, input logic [31:0] wd, input bit f,
                         input bit r, input int ra, input bit rl);
        rst_n = 1'b1;
        wr    = w;
        waddr = AW'(wa);
        wdata = wd;
        full  = f;
        rd    = r;
        raddr = AW'(ra);
        rel   = rl;
        step();
    endtask

    task automatic fill(input logic [31:0] base);
        for (int a = 0; a < D; a++) drive(1, a, base + 32'(a), 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            rst_n = 1'b0;
            wr    = 1'($urandom);
            waddr = AW'($urandom);
            wdata = $urandom;
            full  = 1'($urandom);
            rd    = 1'($urandom);
            raddr = AW'($urandom);
            rel   = 1'($urandom);
            step();
        end
    endtask

    initial begin
        do_reset(2);
        check("rst_space", 32'(space), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", rdata, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // Single window
        fill(32'h100);
        check("win_valid", 32'(valid), 32'd1);
        for (int a = 0; a < D; a++) begin
            drive(0, 0, 0, 0, 1, a, 0);
            check("win_data", rdata, 32'h100 + 32'(a));
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        check("win_rel_valid", 32'(valid), 32'd0);

        // Ping-pong
        fill(32'hA000);
        fill(32'hB000);
        check("pp_space", 32'(space), 32'd0);
        for (int a = 0; a < D; a++) begin
            drive(0, 0, 0, 0, 1, a, 0);
            check("pp_a", rdata, 32'hA000 + 32'(a));
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        check("pp_space_rel", 32'(space), 32'd1);
        for (int a = 0; a < D; a += 7) begin
            drive(0, 0, 0, 0, 1, a, 0);
            check("pp_b", rdata, 32'hB000 + 32'(a));
        end

        // Overflow: write while both banks hold windows
        fill(32'hC000);
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        check("ovf_set", 32'(ovf), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 5, 0);
        check("ovf_word", rdata, 32'hC005);
        check("ovf_sticky", 32'(ovf), 32'd1);

        // Simultaneous completion and release at cnt=2
        do_reset(1);
        fill(32'hD000);
        fill(32'hE000);
        drive(0, 0, 0, 1, 0, 0, 1);
        check("sim_ovf", 32'(ovf), 32'd0);
        check("sim_valid", 32'(valid), 32'd1);
        check("sim_space", 32'(space), 32'd0);
        drive(0, 0, 0, 0, 1, 3, 0);
        check("sim_read", rdata, 32'hE003);
        drive(0, 0, 0, 0, 1, 4, 1);
        check("sim_read_rel", rdata, 32'hE004);
        // Write on the completion cycle belongs to the completed window
        drive(1, 9, 32'h12345678, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 9, 0);
        check("wr_full", rdata, 32'h12345678);

        // Reset mid-operation with a read in flight
        drive(0, 0, 0, 0, 1, 10, 0);
        do_reset(1);
        check("mid_dv", 32'(dvalid), 32'd0);
        check("mid_valid", 32'(valid), 32'd0);
        check("mid_space", 32'(space), 32'd1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1);
            end else begin
                drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)), $urandom,
                      $urandom_range(0, 15) == 0, bit'($urandom_range(0, 1)),
                      int'($urandom_range(0, D - 1)), $urandom_range(0, 13) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
